store_narrower: RTL and testbench
=================================

# store_narrower

Store-side formatter for the datapath's data memory, the counterpart of the load-path sign extension. It takes a 32-bit register value plus a byte address and size (byte / halfword / word) and writes it into a word-organised memory. Word stores are written directly. Sub-word stores use a read-modify-write sequence so that the untouched byte lanes keep their contents. It sits between the execute stage's store request and the data-memory port.

## Interface
Parameters:
- `MEM_LAT`, default 1: data-memory read latency in cycles (≥1).

Ports:
- `clk` input, 1: single clock; all logic is rising-edge.
- `reset` input, 1: synchronous, active-high.
- `req_valid` input, 1: store request present.
- `req_ready` output, 1: block can accept a request (idle).
- `req_addr` input, 32: byte address.
- `req_data` input, 32: register value; low byte or halfword is used for sub-word stores.
- `req_size` input, 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `mem_addr` output, 32: word-aligned address (bits [1:0] = 0).
- `mem_rd_en` output, 1: one-cycle read strobe.
- `mem_rd_data` input, 32: read data, valid exactly `MEM_LAT` cycles after the `mem_rd_en` cycle.
- `mem_wr_en` output, 1: one-cycle write strobe.
- `mem_wr_data` output, 32: full word to write.
- `done` output, 1: one-cycle pulse, asserted with `mem_wr_en`.
- `misaligned` output, 1: one-cycle error pulse.

## Operation
- **Handshake:** a transfer occurs when `req_valid && req_ready`. On that edge the block latches addr, data and size. `req_ready` is 1 only in IDLE.
- **Alignment check at accept:**
  - halfword with addr[0]=1, word with addr[1:0]≠0, or size 11 → ERR.
  - No memory access is made for a rejected request.
- **Lane mapping** (little-endian):
  - Byte lane k = bits [8k+7:8k], with k = addr[1:0].
  - Halfword lane = addr[1] (bits [15:0] or [31:16]).
- **FSM states:** IDLE, READ, WAIT, WRITE, ERR.
  - IDLE → WRITE for a word store.
  - IDLE → READ for a byte or halfword store.
  - IDLE → ERR for a misaligned request.
  - READ: `mem_rd_en`=1, `mem_addr` = {addr[31:2], 2'b00}. READ → WAIT.
  - WAIT: lasts `MEM_LAT` cycles, counted by a down-counter. On the last WAIT cycle, `mem_rd_data` is captured. WAIT → WRITE.
  - WRITE: `mem_wr_en`=1, `done`=1.
    - Word store: `mem_wr_data` = req_data.
    - Sub-word store: `mem_wr_data` = captured word with the selected lane replaced by req_data[7:0] or req_data[15:0].
    - WRITE → IDLE.
  - ERR: `misaligned`=1 for one cycle, then ERR → IDLE.
- **Strobes:** `mem_rd_en` and `mem_wr_en` are never high in the same cycle. `mem_addr` holds its value in READ, WAIT and WRITE and is 0 in IDLE and ERR.
- **Reset:** reset mid-operation aborts the sequence. The block enters IDLE on the next edge, and no write is issued after a reset cycle.

## Timing
- **Reset values:**
  - `req_ready`=1
  - `mem_addr`=0, `mem_rd_en`=0, `mem_wr_en`=0, `mem_wr_data`=0
  - `done`=0, `misaligned`=0
  - FSM in IDLE, WAIT counter 0.
- **Latency**, counting from the accept edge at the end of cycle N:
  - Word store: WRITE/done in cycle N+1.
  - Sub-word store: READ in cycle N+1, WAIT in cycles N+2..N+1+MEM_LAT, WRITE/done in cycle N+2+MEM_LAT (N+3 when `MEM_LAT`=1).
  - Misaligned request: `misaligned` pulse in cycle N+1.
- **Throughput:** the next request can be accepted in the cycle after WRITE or ERR, when `req_ready` has returned to 1. There are no back-to-back accepts.
- `req_*` inputs are ignored while `req_ready`=0.

## Structure
- **Package `store_pkg`:**
  - Size encodings: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state encoding for IDLE, READ, WAIT, WRITE, ERR.
- **Sub-module `lane_merger`** (combinational):
  - Inputs: old word, new data, size, addr[1:0].
  - Output: merged word.
  - Shared with any future store-buffer logic.
- **Top level:** FSM, latched request registers, WAIT counter, captured-read register.

## Test plan
- Word store, addr 0x100, data 0xDEADBEEF → `mem_wr_en` and `done` in cycle N+1, `mem_wr_data`=0xDEADBEEF, `mem_addr`=0x100, no `mem_rd_en`.
- Byte store, addr 0x102, data 0x000000AB, memory returns 0x11223344, `MEM_LAT`=1 → read in N+1, write in N+3 with `mem_wr_data`=0x11AB3344.
- Halfword store, addr 0x206, data 0xFFFF5A5A, memory returns 0xCAFEBABE, `MEM_LAT`=3 → `mem_wr_data`=0x5A5ABABE, written in cycle N+5.
- Halfword at addr 0x301 and word at addr 0x302 → each gives a `misaligned` pulse in N+1 with no memory strobes; `req_ready` is 1 again in N+2.
- Reset asserted during WAIT of a byte store → no `mem_wr_en` thereafter, all outputs at reset values, then a new word store completes normally.

Source files
------------

// File: rtl/store_pkg.sv
// Shared encodings for the store-side formatter: access sizes, FSM states
// and the alignment rule applied when a store request is accepted.
package store_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   // Size 11 is illegal and therefore always rejected like a misaligned access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lane_merger.sv
// Little-endian lane merge: replaces the byte or halfword lane selected by the
// low address bits of an existing word with the low bits of the new data.
module lane_merger
   import store_pkg::*;
(
   input  logic [31:0] old_word_i,
   input  logic [31:0] new_data_i,
   input  logic [1:0]  size_i,
   input  logic [1:0]  lane_i,
   output logic [31:0] merged_o
);

   // Select and overwrite one lane; untouched lanes pass through.
   always_comb begin
      merged_o = old_word_i;
      case (size_i)
         SZ_BYTE: begin
            case (lane_i)
               2'd0:    merged_o[7:0]   = new_data_i[7:0];
               2'd1:    merged_o[15:8]  = new_data_i[7:0];
               2'd2:    merged_o[23:16] = new_data_i[7:0];
               2'd3:    merged_o[31:24] = new_data_i[7:0];
               default: merged_o        = old_word_i;
            endcase
         end
         SZ_HALF: begin
            if (lane_i[1]) begin
               merged_o[31:16] = new_data_i[15:0];
            end else begin
               merged_o[15:0]  = new_data_i[15:0];
            end
         end
         SZ_WORD: merged_o = new_data_i;
         default: merged_o = old_word_i;
      endcase
   end

endmodule

// File: rtl/store_narrower.sv
// Store formatter: word stores are written directly, sub-word stores use a
// read-modify-write of the containing word; misaligned requests raise an error pulse.
module store_narrower
   import store_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   input  logic [1:0]  req_size,
   output logic [31:0] mem_addr,
   output logic        mem_rd_en,
   input  logic [31:0] mem_rd_data,
   output logic        mem_wr_en,
   output logic [31:0] mem_wr_data,
   output logic        done,
   output logic        misaligned
);

   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   state_t         state_q;
   logic [CW-1:0]  wait_cnt_q;
   logic [1:0]     addr_lo_q;
   logic [31:0]    data_q;
   logic [1:0]     size_q;
   logic           ready_q;
   logic [31:0]    mem_addr_q;
   logic           mem_rd_en_q;
   logic           mem_wr_en_q;
   logic [31:0]    mem_wr_data_q;
   logic           done_q;
   logic           misaligned_q;
   logic [31:0]    merged_d;

   // Read data is merged on the fly in the last WAIT cycle, so the
   // write-data register doubles as the captured-read register.
   lane_merger u_lane_merger (
      .old_word_i (mem_rd_data),
      .new_data_i (data_q),
      .size_i     (size_q),
      .lane_i     (addr_lo_q),
      .merged_o   (merged_d)
   );

   // Request FSM with registered strobes, address and write data.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         wait_cnt_q    <= '0;
         addr_lo_q     <= 2'b00;
         data_q        <= 32'h0000_0000;
         size_q        <= 2'b00;
         ready_q       <= 1'b1;
         mem_addr_q    <= 32'h0000_0000;
         mem_rd_en_q   <= 1'b0;
         mem_wr_en_q   <= 1'b0;
         mem_wr_data_q <= 32'h0000_0000;
         done_q        <= 1'b0;
         misaligned_q  <= 1'b0;
      end else begin
         mem_rd_en_q  <= 1'b0;
         mem_wr_en_q  <= 1'b0;
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  addr_lo_q <= req_addr[1:0];
                  data_q    <= req_data;
                  size_q    <= req_size;
                  ready_q   <= 1'b0;
                  if (is_misaligned(req_size, req_addr[1:0])) begin
                     state_q      <= ST_ERR;
                     misaligned_q <= 1'b1;
                  end else if (req_size == SZ_WORD) begin
                     state_q       <= ST_WRITE;
                     mem_addr_q    <= {req_addr[31:2], 2'b00};
                     mem_wr_en_q   <= 1'b1;
                     done_q        <= 1'b1;
                     mem_wr_data_q <= req_data;
                  end else begin
                     state_q     <= ST_READ;
                     mem_addr_q  <= {req_addr[31:2], 2'b00};
                     mem_rd_en_q <= 1'b1;
                  end
               end else begin
                  ready_q <= 1'b1;
               end
            end
            ST_READ: begin
               state_q    <= ST_WAIT;
               wait_cnt_q <= CW'(MEM_LAT - 1);
            end
            ST_WAIT: begin
               if (wait_cnt_q == '0) begin
                  state_q       <= ST_WRITE;
                  mem_wr_en_q   <= 1'b1;
                  done_q        <= 1'b1;
                  mem_wr_data_q <= merged_d;
               end else begin
                  wait_cnt_q <= wait_cnt_q - CW'(1);
               end
            end
            ST_WRITE, ST_ERR: begin
               state_q    <= ST_IDLE;
               ready_q    <= 1'b1;
               mem_addr_q <= 32'h0000_0000;
            end
            default: begin
               state_q    <= ST_IDLE;
               ready_q    <= 1'b1;
               mem_addr_q <= 32'h0000_0000;
            end
         endcase
      end
   end

   assign req_ready   = ready_q;
   assign mem_addr    = mem_addr_q;
   assign mem_rd_en   = mem_rd_en_q;
   assign mem_wr_en   = mem_wr_en_q;
   assign mem_wr_data = mem_wr_data_q;
   assign done        = done_q;
   assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_store_narrower.sv
// Directed bench for store_narrower: a vector table on a MEM_LAT=1 instance
// plus hand sequences (MEM_LAT=3 halfword, reset during WAIT) on a second one.
module tb_store_narrower;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------- DUT with MEM_LAT = 1 ----------------
   logic        v1, rdy1, rd1, wr1, done1, mis1;
   logic [31:0] a1, d1, maddr1, rdat1, wdat1, memval1;
   logic [1:0]  s1;
   logic        rd1_pipe = 1'b0;

   store_narrower #(.MEM_LAT(1)) u1 (
      .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1),
      .req_addr(a1), .req_data(d1), .req_size(s1), .mem_addr(maddr1),
      .mem_rd_en(rd1), .mem_rd_data(rdat1), .mem_wr_en(wr1),
      .mem_wr_data(wdat1), .done(done1), .misaligned(mis1)
   );

   always @(posedge clk) rd1_pipe <= rd1;
   assign rdat1 = rd1_pipe ? memval1 : 32'h0BAD_0BAD;

   // ---------------- DUT with MEM_LAT = 3 ----------------
   logic        v3, rdy3, rd3, wr3, done3, mis3;
   logic [31:0] a3, d3, maddr3, rdat3, wdat3, memval3;
   logic [1:0]  s3;
   logic [2:0]  rd3_pipe = 3'b000;

   store_narrower #(.MEM_LAT(3)) u3 (
      .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rdy3),
      .req_addr(a3), .req_data(d3), .req_size(s3), .mem_addr(maddr3),
      .mem_rd_en(rd3), .mem_rd_data(rdat3), .mem_wr_en(wr3),
      .mem_wr_data(wdat3), .done(done3), .misaligned(mis3)
   );

   always @(posedge clk) rd3_pipe <= {rd3_pipe[1:0], rd3};
   assign rdat3 = rd3_pipe[2] ? memval3 : 32'h0BAD_0BAD;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
      logic [31:0] rd_word;
      logic        exp_mis;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs[12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic run1(input int idx, input vec_t v);
      string t;
      t = $sformatf("v%0d", idx);
      chk({t, "_ready_pre"}, rdy1, 1);
      memval1 = v.rd_word;
      v1 = 1'b1; a1 = v.addr; d1 = v.data; s1 = v.size;
      tick();
      v1 = 1'b0; a1 = 32'hFFFF_FFFF; d1 = 32'h0; s1 = 2'b11;
      chk({t, "_ready_busy"}, rdy1, 0);
      if (v.exp_mis) begin
         chk({t, "_mis"}, mis1, 1);
         chk({t, "_strobes_err"}, {rd1, wr1, done1}, 0);
         chk({t, "_addr_err"}, maddr1, 0);
         tick();
         chk({t, "_mis_off"}, mis1, 0);
      end else if (v.size == 2'b10) begin
         chk({t, "_wr"}, {rd1, wr1, done1, mis1}, 4'b0110);
         chk({t, "_addr"}, maddr1, v.exp_addr);
         chk({t, "_wdata"}, wdat1, v.exp_wdata);
         tick();
      end else begin
         chk({t, "_rd"}, {rd1, wr1, done1, mis1}, 4'b1000);
         chk({t, "_addr_rd"}, maddr1, v.exp_addr);
         tick();
         chk({t, "_wait"}, {rd1, wr1, done1, mis1}, 4'b0000);
         chk({t, "_addr_wait"}, maddr1, v.exp_addr);
         tick();
         chk({t, "_wr"}, {rd1, wr1, done1, mis1}, 4'b0110);
         chk({t, "_addr_wr"}, maddr1, v.exp_addr);
         chk({t, "_wdata"}, wdat1, v.exp_wdata);
         tick();
      end
      chk({t, "_ready_post"}, rdy1, 1);
      chk({t, "_idle"}, {rd1, wr1, done1, mis1}, 4'b0000);
      chk({t, "_addr_idle"}, maddr1, 0);
   endtask

   initial begin
      //          addr          data          size   rd_word       mis   exp_addr      exp_wdata
      vecs[0]  = '{32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 32'h0,        1'b0, 32'h0000_0100, 32'hDEAD_BEEF};
      vecs[1]  = '{32'h0000_0102, 32'h0000_00AB, 2'b00, 32'h1122_3344, 1'b0, 32'h0000_0100, 32'h11AB_3344};
      vecs[2]  = '{32'h0000_0103, 32'h1234_5677, 2'b00, 32'h0000_0000, 1'b0, 32'h0000_0100, 32'h7700_0000};
      vecs[3]  = '{32'h0000_0100, 32'hFFFF_FF01, 2'b00, 32'hAAAA_AAAA, 1'b0, 32'h0000_0100, 32'hAAAA_AA01};
      vecs[4]  = '{32'h0000_0101, 32'h0000_00CC, 2'b00, 32'h1122_3344, 1'b0, 32'h0000_0100, 32'h1122_CC44};
      vecs[5]  = '{32'h0000_0200, 32'h1234_5678, 2'b01, 32'hCAFE_BABE, 1'b0, 32'h0000_0200, 32'hCAFE_5678};
      vecs[6]  = '{32'h0000_0202, 32'h0000_BEEF, 2'b01, 32'h1122_3344, 1'b0, 32'h0000_0200, 32'hBEEF_3344};
      vecs[7]  = '{32'h0000_0301, 32'h1111_1111, 2'b01, 32'h0,        1'b1, 32'h0,          32'h0};
      vecs[8]  = '{32'h0000_0302, 32'h2222_2222, 2'b10, 32'h0,        1'b1, 32'h0,          32'h0};
      vecs[9]  = '{32'h0000_0400, 32'h3333_3333, 2'b11, 32'h0,        1'b1, 32'h0,          32'h0};
      vecs[10] = '{32'h0000_0401, 32'h4444_4444, 2'b10, 32'h0,        1'b1, 32'h0,          32'h0};
      vecs[11] = '{32'hFFFF_FFFE, 32'h0000_005A, 2'b00, 32'h0102_0304, 1'b0, 32'hFFFF_FFFC, 32'h015A_0304};

      reset = 1'b1;
      v1 = 1'b0; a1 = 32'h0; d1 = 32'h0; s1 = 2'b00; memval1 = 32'h0;
      v3 = 1'b0; a3 = 32'h0; d3 = 32'h0; s3 = 2'b00; memval3 = 32'h0;
      tick();
      tick();
      chk("rst_ready1", rdy1, 1);
      chk("rst_outs1", {rd1, wr1, done1, mis1}, 4'b0000);
      chk("rst_addr1", maddr1, 0);
      chk("rst_wdata1", wdat1, 0);
      chk("rst_ready3", rdy3, 1);
      chk("rst_outs3", {rd3, wr3, done3, mis3}, 4'b0000);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 12; i++) begin
         run1(i, vecs[i]);
      end

      // Halfword store with MEM_LAT=3: read N+1, WAIT N+2..N+4, write N+5.
      memval3 = 32'hCAFE_BABE;
      v3 = 1'b1; a3 = 32'h0000_0206; d3 = 32'hFFFF_5A5A; s3 = 2'b01;
      tick();
      v3 = 1'b0;
      chk("h3_rd", {rd3, wr3, done3, mis3}, 4'b1000);
      chk("h3_addr_rd", maddr3, 32'h0000_0204);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("h3_wait%0d", c), {rd3, wr3, done3, mis3, rdy3}, 5'b00000);
         chk($sformatf("h3_addr_wait%0d", c), maddr3, 32'h0000_0204);
      end
      tick();
      chk("h3_wr", {rd3, wr3, done3, mis3}, 4'b0110);
      chk("h3_wdata", wdat3, 32'h5A5A_BABE);
      chk("h3_addr_wr", maddr3, 32'h0000_0204);
      tick();
      chk("h3_ready_post", rdy3, 1);

      // Reset during WAIT of a byte store aborts without any write.
      memval3 = 32'h7777_7777;
      v3 = 1'b1; a3 = 32'h0000_0010; d3 = 32'h0000_0099; s3 = 2'b00;
      tick();
      v3 = 1'b0;
      chk("rw_rd", rd3, 1);
      tick();
      chk("rw_in_wait", {rd3, wr3}, 2'b00);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rw_ready", rdy3, 1);
      chk("rw_outs", {rd3, wr3, done3, mis3}, 4'b0000);
      chk("rw_addr", maddr3, 0);
      chk("rw_wdata", wdat3, 0);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("rw_nowr%0d", c), {wr3, done3}, 2'b00);
      end
      chk("rw_ready_idle", rdy3, 1);
      v3 = 1'b1; a3 = 32'h0000_0080; d3 = 32'h1357_9BDF; s3 = 2'b10;
      tick();
      v3 = 1'b0;
      chk("rw_word_wr", {rd3, wr3, done3, mis3}, 4'b0110);
      chk("rw_word_wdata", wdat3, 32'h1357_9BDF);
      chk("rw_word_addr", maddr3, 32'h0000_0080);
      tick();
      chk("rw_word_ready", rdy3, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
